// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and types for the SPI transfer sequencer
//
// Purpose: state encoding, default geometry and requester indices used by
//          spi_xfer_seq and spi_rr_arb2.
// Ports:   none (package).
package spi_pkg;

  localparam int BITS_DEF  = 8;
  localparam int LEN_W_DEF = 4;

  localparam int REQ_CPU  = 0;
  localparam int REQ_AUTO = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/spi_rr_arb2.sv
// rtl/spi_rr_arb2.sv - two-way round-robin arbiter with last-winner register
//
// Purpose: picks one of two requesters; on a tie the requester that did not
//          win last time gets the grant. The last-winner register only moves
//          when i_en is high and at least one request is present.
// Ports:
//   inv_serclk  in   inverted serial clock, rising edge active
//   reset       in   asynchronous, active-high
//   i_req[1:0]  in   request per requester
//   i_en        in   commit the current pick as the new last winner
//   o_gnt[1:0]  out  one-hot combinational pick (00 when no request)
module spi_rr_arb2
  import spi_pkg::*;
(
  input  logic       inv_serclk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  // High when the auto-read requester won last; reset value makes the
  // CPU path win the first tie.
  logic r_last_auto;
  logic w_pick_auto;

  assign w_pick_auto      = i_req[REQ_AUTO] & (~i_req[REQ_CPU] | ~r_last_auto);
  assign o_gnt[REQ_AUTO]  = w_pick_auto;
  assign o_gnt[REQ_CPU]   = i_req[REQ_CPU] & ~w_pick_auto;

  always_ff @(posedge inv_serclk or posedge reset) begin
    if (reset) begin
      r_last_auto <= 1'b1;
    end else if (i_en && (i_req != 2'b00)) begin
      r_last_auto <= w_pick_auto;
    end
  end

endmodule

// File: rtl/spi_xfer_seq.sv
// rtl/spi_xfer_seq.sv - SPI burst sequencer: arbitration, chip-select, bit/byte counting
//
// Purpose: grants the SPI byte engine to one of two requesters, frames the
//          burst with chip-select setup/hold cycles and enables the shift
//          registers for BITS*(len+1) back-to-back cycles.
// Ports:
//   inv_serclk      in   inverted serial clock, rising edge active
//   reset           in   asynchronous, active-high
//   req[1:0]        in   level request per requester, held until xfer_done
//   len0, len1      in   burst length-1 per requester, sampled at grant
//   abort           in   synchronous abort of the current burst
//   grant[1:0]      out  one-hot engine owner, 00 when idle
//   cs_n            out  chip-select, active low
//   shift_en        out  shift register enable
//   bit_cnt         out  bit index within the current byte
//   byte_done       out  last shift cycle of a byte
//   xfer_done       out  one-cycle end-of-burst pulse
//   busy            out  high from grant until return to idle
module spi_xfer_seq
  import spi_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                     inv_serclk,
  input  logic                     reset,
  input  logic [1:0]               req,
  input  logic [LEN_W-1:0]         len0,
  input  logic [LEN_W-1:0]         len1,
  input  logic                     abort,
  output logic [1:0]               grant,
  output logic                     cs_n,
  output logic                     shift_en,
  output logic [$clog2(BITS)-1:0]  bit_cnt,
  output logic                     byte_done,
  output logic                     xfer_done,
  output logic                     busy
);

  localparam int            BW       = $clog2(BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS - 1);

  state_t             r_state,     w_state_nxt;
  logic [1:0]         r_grant,     w_grant_nxt;
  logic               r_cs_n,      w_cs_n_nxt;
  logic               r_shift_en,  w_shift_en_nxt;
  logic [BW-1:0]      r_bit_cnt,   w_bit_cnt_nxt;
  logic [LEN_W-1:0]   r_byte_cnt,  w_byte_cnt_nxt;
  logic               r_busy,      w_busy_nxt;
  logic               r_xfer_done, w_xfer_done_nxt;

  logic               w_arb_en;
  logic [1:0]         w_win;

  spi_rr_arb2 u_arb (
    .inv_serclk (inv_serclk),
    .reset      (reset),
    .i_req      (req),
    .i_en       (w_arb_en),
    .o_gnt      (w_win)
  );

  always_ff @(posedge inv_serclk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_grant     <= 2'b00;
      r_cs_n      <= 1'b1;
      r_shift_en  <= 1'b0;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_busy      <= 1'b0;
      r_xfer_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_cs_n      <= w_cs_n_nxt;
      r_shift_en  <= w_shift_en_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_busy      <= w_busy_nxt;
      r_xfer_done <= w_xfer_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_cs_n_nxt      = r_cs_n;
    w_shift_en_nxt  = r_shift_en;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_busy_nxt      = r_busy;
    w_xfer_done_nxt = 1'b0;
    w_arb_en        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Only IDLE looks at req, so requests are non-preemptive.
        if (req != 2'b00) begin
          w_arb_en       = 1'b1;
          w_grant_nxt    = w_win;
          w_byte_cnt_nxt = w_win[REQ_AUTO] ? len1 : len0;
          w_cs_n_nxt     = 1'b0;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (abort) begin
          w_state_nxt = ST_HOLD;
        end else begin
          w_shift_en_nxt = 1'b1;
          w_bit_cnt_nxt  = '0;
          w_state_nxt    = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (abort) begin
          w_shift_en_nxt = 1'b0;
          w_bit_cnt_nxt  = '0;
          w_state_nxt    = ST_HOLD;
        end else if (r_bit_cnt == BIT_LAST) begin
          w_bit_cnt_nxt = '0;
          // Byte counter holds remaining bytes after this one; stop at
          // zero rather than decrementing so it never wraps.
          if (r_byte_cnt == '0) begin
            w_shift_en_nxt = 1'b0;
            w_state_nxt    = ST_HOLD;
          end else begin
            w_byte_cnt_nxt = r_byte_cnt - 1'b1;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end

      ST_HOLD: begin
        w_cs_n_nxt      = 1'b1;
        w_grant_nxt     = 2'b00;
        w_busy_nxt      = 1'b0;
        w_xfer_done_nxt = 1'b1;
        w_state_nxt     = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign grant     = r_grant;
  assign cs_n      = r_cs_n;
  assign shift_en  = r_shift_en;
  assign bit_cnt   = r_bit_cnt;
  assign busy      = r_busy;
  assign xfer_done = r_xfer_done;
  // Decoded rather than registered so it lines up with the final shift edge.
  assign byte_done = r_shift_en & (r_bit_cnt == BIT_LAST);

endmodule

// File: tb/tb_spi_xfer_seq.sv
// tb/tb_spi_xfer_seq.sv - self-checking bench for spi_xfer_seq
module tb_spi_xfer_seq;

  localparam int BITS  = spi_pkg::BITS_DEF;
  localparam int LEN_W = spi_pkg::LEN_W_DEF;
  localparam int BW    = $clog2(BITS);

  logic             inv_serclk = 1'b0;
  logic             reset;
  logic [1:0]       req;
  logic [LEN_W-1:0] len0, len1;
  logic             abort;
  logic [1:0]       grant;
  logic             cs_n, shift_en, byte_done, xfer_done, busy;
  logic [BW-1:0]    bit_cnt;

  spi_xfer_seq #(.BITS(BITS), .LEN_W(LEN_W)) dut (
    .inv_serclk (inv_serclk),
    .reset      (reset),
    .req        (req),
    .len0       (len0),
    .len1       (len1),
    .abort      (abort),
    .grant      (grant),
    .cs_n       (cs_n),
    .shift_en   (shift_en),
    .bit_cnt    (bit_cnt),
    .byte_done  (byte_done),
    .xfer_done  (xfer_done),
    .busy       (busy)
  );

  always #5 inv_serclk = ~inv_serclk;

  int checks = 0;
  int errors = 0;

  // Burst timeline model: t counts cycles since the grant edge.
  // t=1 setup, t=2..nbits+1 shifting, t=nbits+2 hold, t=nbits+3 idle with xfer_done.
  bit m_active;
  int m_t, m_nbits, m_last, m_owner;

  logic [1:0] e_grant;
  logic       e_cs_n, e_shift, e_busy, e_xfer, e_bd;
  int         e_bit;

  int n_shift, n_bd, n_xfer, n_csh;
  bit auto_drop;
  logic [1:0] prev_grant;
  logic [1:0] gq[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_idle();
    return !m_active || (m_t == m_nbits + 3);
  endfunction

  task automatic model_reset();
    m_active   = 1'b0;
    m_t        = 0;
    m_nbits    = 0;
    m_last     = 1;
    prev_grant = 2'b00;
  endtask

  task automatic model_step();
    int w;
    if (model_idle()) begin
      m_active = 1'b0;
      if (req != 2'b00) begin
        if (req == 2'b01)      w = 0;
        else if (req == 2'b10) w = 1;
        else                   w = (m_last == 1) ? 0 : 1;
        m_last   = w;
        m_owner  = w;
        m_active = 1'b1;
        m_t      = 1;
        m_nbits  = BITS * ((w == 1 ? int'(len1) : int'(len0)) + 1);
      end
    end else begin
      if (abort && m_t <= m_nbits + 1) m_nbits = m_t - 1;
      m_t++;
    end
    e_grant = 2'b00; e_cs_n = 1'b1; e_shift = 1'b0; e_busy = 1'b0; e_xfer = 1'b0; e_bit = 0;
    if (m_active) begin
      if (m_t == m_nbits + 3) begin
        e_xfer = 1'b1;
      end else begin
        e_grant = (m_owner == 1) ? 2'b10 : 2'b01;
        e_cs_n  = 1'b0;
        e_busy  = 1'b1;
        if (m_t >= 2 && m_t <= m_nbits + 1) begin
          e_shift = 1'b1;
          e_bit   = (m_t - 2) % BITS;
        end
      end
    end
    e_bd = e_shift && (e_bit == BITS - 1);
  endtask

  task automatic cycle();
    @(posedge inv_serclk);
    model_step();
    @(negedge inv_serclk);
    check_eq("grant", grant, e_grant);
    check_eq("cs_n", cs_n, e_cs_n);
    check_eq("shift_en", shift_en, e_shift);
    check_eq("busy", busy, e_busy);
    check_eq("xfer_done", xfer_done, e_xfer);
    check_eq("byte_done", byte_done, e_bd);
    if (e_shift) check_eq("bit_cnt", bit_cnt, e_bit);
    n_shift += int'(shift_en);
    n_bd    += int'(byte_done);
    n_xfer  += int'(xfer_done);
    n_csh   += int'(cs_n);
    if (grant != 2'b00 && prev_grant == 2'b00) gq.push_back(grant);
    prev_grant = grant;
    if (auto_drop && e_xfer) req[m_owner] = 1'b0;
  endtask

  task automatic clear_counts();
    n_shift = 0; n_bd = 0; n_xfer = 0; n_csh = 0;
    gq.delete();
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < budget) begin
      cycle();
      n++;
      done = model_idle() && (req == 2'b00);
    end
    check_eq("idle_reached", done, 1);
  endtask

  function automatic logic [LEN_W-1:0] pick_len();
    if ($urandom_range(9) == 0) return LEN_W'($urandom_range(15));
    return LEN_W'($urandom_range(2));
  endfunction

  initial begin
    int n;
    reset = 1'b1; req = 2'b00; len0 = '0; len1 = '0; abort = 1'b0;
    auto_drop = 1'b1;
    model_reset();
    clear_counts();
    repeat (2) @(negedge inv_serclk);
    check_eq("rst_grant", grant, 2'b00);
    check_eq("rst_cs_n", cs_n, 1'b1);
    check_eq("rst_shift_en", shift_en, 1'b0);
    check_eq("rst_bit_cnt", bit_cnt, 0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_xfer_done", xfer_done, 1'b0);
    check_eq("rst_byte_done", byte_done, 1'b0);
    reset = 1'b0;

    // Single byte from the CPU path
    clear_counts();
    req = 2'b01; len0 = 4'd0;
    run_until_idle(50);
    check_eq("a_shift_cycles", n_shift, 8);
    check_eq("a_byte_done", n_bd, 1);
    check_eq("a_xfer_done", n_xfer, 1);

    // Three bytes from the auto-read path
    clear_counts();
    req = 2'b10; len1 = 4'd2;
    run_until_idle(60);
    check_eq("b_shift_cycles", n_shift, 24);
    check_eq("b_byte_done", n_bd, 3);
    check_eq("b_xfer_done", n_xfer, 1);

    // Both requesting continuously: alternate with one idle cycle between
    clear_counts();
    auto_drop = 1'b0;
    req = 2'b11; len0 = 4'd0; len1 = 4'd0;
    n = 0;
    while (gq.size() < 3 && n < 60) begin cycle(); n++; end
    check_eq("c_grants_seen", gq.size(), 3);
    if (gq.size() == 3) begin
      check_eq("c_grant0", gq[0], 2'b01);
      check_eq("c_grant1", gq[1], 2'b10);
      check_eq("c_grant2", gq[2], 2'b01);
    end
    check_eq("c_cs_high_cycles", n_csh, 2);
    req = 2'b00;
    auto_drop = 1'b1;
    run_until_idle(30);

    // Abort at bit 3 of the second byte of a four-byte burst
    clear_counts();
    req = 2'b01; len0 = 4'd3;
    n = 0;
    while (!(m_active && m_t == 13) && n < 50) begin cycle(); n++; end
    check_eq("d_reached_bit3", bit_cnt, 3);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    run_until_idle(20);
    check_eq("d_shift_cycles", n_shift, 12);
    check_eq("d_byte_done", n_bd, 1);
    check_eq("d_xfer_done", n_xfer, 1);

    // Longest burst
    clear_counts();
    req = 2'b01; len0 = 4'd15;
    run_until_idle(200);
    check_eq("e_shift_cycles", n_shift, 128);
    check_eq("e_byte_done", n_bd, 16);
    check_eq("e_xfer_done", n_xfer, 1);

    // Asynchronous reset in the middle of a long burst
    req = 2'b01; len0 = 4'd15;
    n = 0;
    while (!(m_active && m_t == 20) && n < 50) begin cycle(); n++; end
    check_eq("f_mid_shift", shift_en, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_eq("f_async_cs_n", cs_n, 1'b1);
    check_eq("f_async_shift_en", shift_en, 1'b0);
    check_eq("f_async_grant", grant, 2'b00);
    check_eq("f_async_busy", busy, 1'b0);
    model_reset();
    clear_counts();
    req = 2'b11;
    @(negedge inv_serclk);
    reset = 1'b0;
    run_until_idle(300);
    check_eq("f_first_grant", (gq.size() > 0) ? gq[0] : 2'b00, 2'b01);
    check_eq("f_xfer_done", n_xfer, 2);

    // Random traffic
    clear_counts();
    for (int c = 0; c < 3000; c++) begin
      if (!req[0] && $urandom_range(7) == 0) req[0] = 1'b1;
      if (!req[1] && $urandom_range(7) == 0) req[1] = 1'b1;
      len0  = pick_len();
      len1  = pick_len();
      abort = ($urandom_range(29) == 0);
      cycle();
    end
    abort = 1'b0;
    run_until_idle(600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
